// File: rtl/baud_gen_nco.sv
// Phase-accumulator (NCO) baud-rate generator with programmable increment.
// Define BAUD_GEN_OVS_EN to add the oversampling divider (ovs_tick, bit-centre restart).
module baud_gen_nco #(
   parameter int unsigned CLK_FREQ     = 24_000_000,
   parameter int unsigned BAUD_DEFAULT = 9600,
   parameter int unsigned ACC_W        = 24,
   parameter int unsigned OVS          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             inc_wr,
   input  logic [ACC_W-1:0] inc_wdata,
   output logic [ACC_W-1:0] inc,
   output logic             ovs_tick,
   output logic             baud_tick
);

`ifdef BAUD_GEN_OVS_EN
   localparam bit OVS_EN = 1'b1;
`else
   localparam bit OVS_EN = 1'b0;
`endif

   // Rounded default increment, evaluated in 64 bits so ACC_W up to 32 cannot overflow.
   localparam logic [63:0] MULT  = OVS_EN ? 64'(OVS) : 64'd1;
   localparam logic [63:0] CLK64 = 64'(CLK_FREQ);
   localparam logic [63:0] NUM   = (64'(BAUD_DEFAULT) * MULT) << ACC_W;
   localparam logic [63:0] INC64 = (NUM + (CLK64 >> 1)) / CLK64;
   localparam logic [ACC_W-1:0] INC0 = INC64[ACC_W-1:0];

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             carry;

   // One extra bit holds the wrap, so even inc >= 2^(ACC_W-1) yields at most one carry per add.
   assign sum   = {1'b0, acc} + {1'b0, inc};
   assign carry = sum[ACC_W];

`ifdef BAUD_GEN_OVS_EN
   localparam int unsigned DIV_W = $clog2(OVS);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(OVS / 2);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS - 1);

   logic [DIV_W-1:0] div;

   // NOTE: every register here uses <= so all state updates see the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         inc       <= INC0;
         div       <= '0;
         ovs_tick  <= 1'b0;
         baud_tick <= 1'b0;
      end else begin
         if (inc_wr)
            inc <= inc_wdata;
         if (restart) begin
            acc       <= '0;
            div       <= DIV_HALF;
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
         end else if (en) begin
            acc       <= sum[ACC_W-1:0];
            ovs_tick  <= carry;
            baud_tick <= carry && (div == DIV_LAST);
            if (carry)
               div <= div + DIV_W'(1);
         end else begin
            ovs_tick  <= 1'b0;
            baud_tick <= 1'b0;
         end
      end
   end
`else
   assign ovs_tick = 1'b0;

   // NOTE: every register here uses <= so all state updates see the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         inc       <= INC0;
         baud_tick <= 1'b0;
      end else begin
         if (inc_wr)
            inc <= inc_wdata;
         if (restart) begin
            acc       <= '0;
            baud_tick <= 1'b0;
         end else if (en) begin
            acc       <= sum[ACC_W-1:0];
            baud_tick <= carry;
         end else begin
            baud_tick <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_baud_gen_nco.sv
// Randomized self-checking bench for baud_gen_nco; reference model tracks unbounded total phase
// and counts multiples of 2^ACC_W crossed (works with or without BAUD_GEN_OVS_EN).
module tb_baud_gen_nco;
   localparam int unsigned ACC_W = 24;
   localparam int unsigned OVS   = 16;
   localparam longint unsigned FULL = 64'd1 << ACC_W;
`ifdef BAUD_GEN_OVS_EN
   localparam bit OVS_MODE = 1'b1;
   localparam logic [ACC_W-1:0] INC0_EXP = 24'd107374;
`else
   localparam bit OVS_MODE = 1'b0;
   localparam logic [ACC_W-1:0] INC0_EXP = 24'd6711;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic restart = 1'b0;
   logic inc_wr = 1'b0;
   logic [ACC_W-1:0] inc_wdata = '0;
   logic [ACC_W-1:0] inc;
   logic ovs_tick, baud_tick;

   baud_gen_nco #(
      .CLK_FREQ(24_000_000), .BAUD_DEFAULT(9600), .ACC_W(ACC_W), .OVS(OVS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .inc_wr(inc_wr),
      .inc_wdata(inc_wdata), .inc(inc), .ovs_tick(ovs_tick), .baud_tick(baud_tick)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: total phase, ovs pulses since the last restart/reset, bit-centre offset.
   longint unsigned  p;
   logic [ACC_W-1:0] m_inc;
   int               n_ovs, off;
   logic             e_ovs, e_baud;
   // Per-window statistics.
   int mis, nb, no, cyc, last_b, min_sp, max_sp;

   task automatic model_reset();
      p = 0; m_inc = INC0_EXP; n_ovs = 0; off = 0; e_ovs = 1'b0; e_baud = 1'b0;
   endtask

   task automatic clear_stats();
      mis = 0; nb = 0; no = 0; last_b = -1; min_sp = 1 << 30; max_sp = 0;
   endtask

   // One clock: update the model on the edge, compare outputs 1 ns later.
   task automatic step();
      logic crossed;
      @(posedge clk);
      if (restart) begin
         p = 0; n_ovs = 0; off = OVS / 2; e_ovs = 1'b0; e_baud = 1'b0;
      end else if (en) begin
         crossed = ((p + m_inc) / FULL) != (p / FULL);
         p = p + m_inc;
         if (OVS_MODE) begin
            e_ovs = crossed;
            if (crossed) n_ovs++;
            e_baud = crossed && (((n_ovs + off) % OVS) == 0);
         end else begin
            e_ovs = 1'b0;
            e_baud = crossed;
         end
      end else begin
         e_ovs = 1'b0; e_baud = 1'b0;
      end
      if (inc_wr) m_inc = inc_wdata;
      #1;
      cyc++;
      if (baud_tick !== e_baud) mis++;
      if (ovs_tick !== e_ovs) mis++;
      if (inc !== m_inc) mis++;
      if (baud_tick === 1'b1) begin
         nb++;
         if (last_b >= 0) begin
            if (cyc - last_b < min_sp) min_sp = cyc - last_b;
            if (cyc - last_b > max_sp) max_sp = cyc - last_b;
         end
         last_b = cyc;
      end
      if (ovs_tick === 1'b1) no++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic write_inc(input logic [ACC_W-1:0] v);
      inc_wdata = v; inc_wr = 1'b1;
      step();
      inc_wr = 1'b0;
   endtask

   // Steps until the first accumulator carry is visible (ovs_tick with divider, else baud_tick).
   task automatic cycles_to_carry(output int n);
      n = 0;
      for (int i = 1; i <= 10000; i++) begin
         step();
         if ((OVS_MODE ? ovs_tick : baud_tick) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_baud(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         step();
         if (baud_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int n;
      bit ok;
      logic [ACC_W-1:0] v;
      cyc = 0;
      model_reset();
      clear_stats();

      // Reset state.
      #12;
      check("reset_inc", inc, INC0_EXP);
      check("reset_baud", baud_tick, 0);
      check("reset_ovs", ovs_tick, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      en = 1'b1;

      // Default rate from acc=0: carries after N adds = floor(N*inc/2^ACC_W).
      clear_stats();
      run(30000);
      check("default_model", mis, 0);
      if (OVS_MODE) begin
         check("default_ovs_count", no, (64'd30000 * INC0_EXP) / FULL);
         check("default_baud_count", nb, ((64'd30000 * INC0_EXP) / FULL) / OVS);
      end else begin
         check("default_baud_count", nb, (64'd30000 * INC0_EXP) / FULL);
         check("default_spacing_ok", (min_sp >= 2499) && (max_sp <= 2500), 1);
         check("default_ovs_count", no, 0);
      end

      // Phase-continuous rate change mid-period.
      run(100 + $urandom_range(0, 1500));
      write_inc(24'd80531);
      check("inc_readback", inc, 80531);
      clear_stats();
      run(3000);
      check("switch_model", mis, 0);
      if (!OVS_MODE) check("switch_spacing_ok", (min_sp >= 208) && (max_sp <= 209), 1);

      // Freeze for 1000 cycles mid-period, then resume until the next tick.
      wait_baud(ok);
      check("freeze_found_tick", ok, 1);
      run($urandom_range(1, 100));
      clear_stats();
      en = 1'b0;
      run(1000);
      check("freeze_no_ticks", nb + no, 0);
      en = 1'b1;
      wait_baud(ok);
      check("freeze_resume_tick", ok, 1);
      check("freeze_model", mis, 0);

      // Restart: first carry after a full period from acc=0.
      write_inc(INC0_EXP);
      run($urandom_range(10, 1000));
      restart = 1'b1; step(); restart = 1'b0;
      cycles_to_carry(n);
      check("restart_first_carry", n, (FULL + INC0_EXP - 1) / INC0_EXP);
`ifdef BAUD_GEN_OVS_EN
      // Bit-centre alignment: baud on 8th ovs pulse after restart, then every 16.
      restart = 1'b1; step(); restart = 1'b0;
      clear_stats();
      for (int i = 0; i < 20000 && nb == 0; i++) step();
      check("restart_ovs_to_first_baud", no, OVS / 2);
      clear_stats();
      for (int i = 0; i < 20000 && nb == 0; i++) step();
      check("restart_ovs_to_next_baud", no, OVS);
`endif

      // Randomized soak: en, restart, inc_wr (incl. 0 and >= 2^(ACC_W-1)), coincident restart+write.
      clear_stats();
      for (int i = 0; i < 15000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         restart = ($urandom_range(0, 299) == 0);
         inc_wr = ($urandom_range(0, 499) == 0) || (restart && $urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: v = '0;
            1: v = ACC_W'($urandom_range(1000, 200000));
            2: v = ACC_W'($urandom_range(32'h80_0000, 32'hFF_FFFF));
            default: v = '1;
         endcase
         inc_wdata = v;
         step();
      end
      restart = 1'b0; inc_wr = 1'b0; en = 1'b1;
      check("soak_model", mis, 0);

      // inc = 0 never ticks.
      write_inc('0);
      clear_stats();
      run(3000);
      check("zero_inc_ticks", nb + no, 0);
      check("zero_inc_model", mis, 0);

      // Asynchronous reset between edges, right after a tick.
      write_inc(24'd80531);
      wait_baud(ok);
      check("async_found_tick", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_baud_cleared", baud_tick, 0);
      check("async_ovs_cleared", ovs_tick, 0);
      check("async_inc_default", inc, INC0_EXP);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      clear_stats();
      cycles_to_carry(n);
      check("async_first_carry", n, (FULL + INC0_EXP - 1) / INC0_EXP);
      check("async_model", mis, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
